// File: rtl/params_pkg.sv
// Shared core parameters and types for the 64-bit RISC-V pipeline.
// Fetch-stage additions: queue depth, reset PC and the queued entry layout.
package params_pkg;

  localparam int INST_WIDTH                = 32;
  localparam int RISC_V_DATA_WIDTH         = 64;
  localparam int INST_MEMORY_ADDRESS_WIDTH = 8;
  localparam int FETCH_QUEUE_DEPTH         = 2;

  localparam logic [RISC_V_DATA_WIDTH-1:0] RESET_PC = 64'h0;
  localparam logic [INST_WIDTH-1:0]        NOP      = 32'h00000013;

  typedef struct packed {
    logic [RISC_V_DATA_WIDTH-1:0] pc;
    logic [INST_WIDTH-1:0]        inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Two-entry FIFO of fetched instructions with push, pop and flush.
// Slot 0 is always the head, so the head output needs no read pointer.
module fetch_queue
  import params_pkg::fetch_entry_t;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output logic [1:0]   count,
  output fetch_entry_t head,
  output logic         head_valid
);

  fetch_entry_t slot0;
  fetch_entry_t slot1;
  logic         do_pop;

  assign do_pop     = pop && (count != 2'd0);
  assign head       = slot0;
  assign head_valid = (count != 2'd0);

  // A pop shifts slot 1 forward; a simultaneous push lands in the slot that frees up.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot0 <= '0;
      slot1 <= '0;
      count <= 2'd0;
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      unique case ({push, do_pop})
        2'b11: begin
          if (count == 2'd1) begin
            slot0 <= push_data;
          end else begin
            slot0 <= slot1;
            slot1 <= push_data;
          end
        end
        2'b10: begin
          if (count == 2'd0) slot0 <= push_data;
          else               slot1 <= push_data;
          count <= count + 2'd1;
        end
        2'b01: begin
          slot0 <= slot1;
          count <= count - 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/inst_fetch_stage.sv
// Instruction fetch: owns the PC, issues word reads to the synchronous
// instruction memory and queues responses for decode; redirects flush and restart.
module inst_fetch_stage
  import params_pkg::fetch_entry_t;
  import params_pkg::NOP;
#(
  parameter int                           INST_WIDTH                = 32,
  parameter int                           RISC_V_DATA_WIDTH         = 64,
  parameter int                           INST_MEMORY_ADDRESS_WIDTH = 8,
  parameter int                           FETCH_QUEUE_DEPTH         = 2,
  parameter logic [RISC_V_DATA_WIDTH-1:0] RESET_PC                  = params_pkg::RESET_PC
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  output logic                                 imem_en,
  output logic [INST_MEMORY_ADDRESS_WIDTH-1:0] imem_addr,
  input  logic [INST_WIDTH-1:0]                imem_rdata,
  input  logic                                 redirect_valid,
  input  logic [RISC_V_DATA_WIDTH-1:0]         redirect_pc,
  output logic                                 if_valid,
  output logic [INST_WIDTH-1:0]                if_inst,
  output logic [RISC_V_DATA_WIDTH-1:0]         if_pc,
  input  logic                                 id_ready
);

  localparam logic [1:0] DEPTH = 2'(FETCH_QUEUE_DEPTH);

  logic [RISC_V_DATA_WIDTH-1:0] pc;
  logic [RISC_V_DATA_WIDTH-1:0] inflight_pc;
  logic                         inflight;
  logic [1:0]                   occupancy;
  logic [1:0]                   occ_after_pop;
  fetch_entry_t                 head;
  fetch_entry_t                 push_data;
  logic                         head_valid;
  logic                         pop;
  logic                         push;
  logic                         issue;
  logic                         redirect_pc_unused;

  assign redirect_pc_unused = ^redirect_pc[1:0];

  // A redirect discards this cycle's handshake and kills the returning response.
  assign pop  = head_valid && id_ready && !redirect_valid;
  assign push = inflight && !redirect_valid;

  // Count the slot being freed this cycle so a draining queue keeps issuing back-to-back.
  assign occ_after_pop = occupancy - {1'b0, pop};
  assign issue = rst_n && !redirect_valid &&
                 ((occ_after_pop + {1'b0, inflight}) < DEPTH);

  assign push_data.pc   = inflight_pc;
  assign push_data.inst = imem_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      inflight_pc <= '0;
      inflight    <= 1'b0;
    end else begin
      inflight <= issue;
      if (redirect_valid) begin
        pc <= {redirect_pc[RISC_V_DATA_WIDTH-1:2], 2'b00};
      end else if (issue) begin
        pc          <= pc + 64'd4;
        inflight_pc <= pc;
      end
    end
  end

  fetch_queue u_fetch_queue (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_data  (push_data),
    .pop        (pop),
    .flush      (redirect_valid),
    .count      (occupancy),
    .head       (head),
    .head_valid (head_valid)
  );

  assign imem_en   = issue;
  assign imem_addr = pc[INST_MEMORY_ADDRESS_WIDTH-1:0];
  assign if_valid  = head_valid;
  assign if_inst   = head_valid ? head.inst : NOP;
  assign if_pc     = head_valid ? head.pc   : '0;

endmodule

// File: tb/tb_inst_fetch_stage.sv
// Directed self-checking bench for inst_fetch_stage; memory word i holds 0x1000+i.
module tb_inst_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_en;
  logic [7:0]  imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        if_valid;
  logic [31:0] if_inst;
  logic [63:0] if_pc;
  logic        id_ready = 1'b1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Synchronous instruction memory: data appears the cycle after the request.
  always @(posedge clk) begin
    if (imem_en) imem_rdata <= 32'h1000 + 32'(imem_addr[7:2]);
  end

  inst_fetch_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_en        (imem_en),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_inst        (if_inst),
    .if_pc          (if_pc),
    .id_ready       (id_ready)
  );

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkHead(input string tag, input logic v, input logic [31:0] inst, input logic [63:0] pc);
    checkOutput({tag, " if_valid"}, 64'(if_valid), 64'(v));
    checkOutput({tag, " if_inst"},  64'(if_inst),  64'(inst));
    checkOutput({tag, " if_pc"},    if_pc,         pc);
  endtask

  task automatic checkFetch(input string tag, input logic en, input logic [7:0] addr);
    checkOutput({tag, " imem_en"}, 64'(imem_en), 64'(en));
    if (en) checkOutput({tag, " imem_addr"}, 64'(imem_addr), 64'(addr));
  endtask

  // Advance to the next cycle's mid-point, drive inputs, then settle before sampling.
  task automatic applyStimulus(input logic rdy, input logic rv, input logic [63:0] rpc);
    @(negedge clk);
    id_ready       = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    #1;
  endtask

  // Holds reset, checks reset outputs, and releases it so the caller is in cycle 0.
  task automatic resetDut(input string tag);
    @(negedge clk);
    rst_n          = 1'b0;
    id_ready       = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    repeat (2) @(negedge clk);
    #1;
    checkFetch({tag, " reset"}, 1'b0, 8'h00);
    checkHead({tag, " reset"}, 1'b0, 32'h00000013, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    // Steady streaming with decode always ready.
    resetDut("A");
    checkFetch("A c0", 1'b1, 8'h00);
    checkOutput("A c0 if_valid", 64'(if_valid), 64'd0);
    applyStimulus(1'b1, 1'b0, 64'h0);
    checkFetch("A c1", 1'b1, 8'h04);
    checkOutput("A c1 if_valid", 64'(if_valid), 64'd0);
    for (int k = 2; k <= 6; k++) begin
      applyStimulus(1'b1, 1'b0, 64'h0);
      checkFetch($sformatf("A c%0d", k), 1'b1, 8'(4 * k));
      checkHead($sformatf("A c%0d", k), 1'b1, 32'h1000 + 32'(k - 2), 64'(4 * (k - 2)));
    end

    // Decode stalls for 5 cycles: queue fills, fetch stops, then resumes without a bubble.
    resetDut("B");
    applyStimulus(1'b1, 1'b0, 64'h0);
    for (int k = 2; k <= 6; k++) begin
      applyStimulus(1'b0, 1'b0, 64'h0);
      checkFetch($sformatf("B c%0d", k), 1'b0, 8'h00);
      checkHead($sformatf("B c%0d", k), 1'b1, 32'h1000, 64'h0);
    end
    applyStimulus(1'b1, 1'b0, 64'h0);
    checkFetch("B c7", 1'b1, 8'h08);
    checkHead("B c7", 1'b1, 32'h1000, 64'h0);
    for (int k = 8; k <= 11; k++) begin
      applyStimulus(1'b1, 1'b0, 64'h0);
      checkHead($sformatf("B c%0d", k), 1'b1, 32'h1000 + 32'(k - 7), 64'(4 * (k - 7)));
    end

    // Redirect to 0x40 in cycle 5 drops the in-flight response.
    resetDut("C");
    repeat (4) applyStimulus(1'b1, 1'b0, 64'h0);
    applyStimulus(1'b1, 1'b1, 64'h40);
    checkFetch("C c5", 1'b0, 8'h00);
    checkHead("C c5", 1'b1, 32'h1003, 64'hC);
    applyStimulus(1'b1, 1'b0, 64'h0);
    checkFetch("C c6", 1'b1, 8'h40);
    checkOutput("C c6 if_valid", 64'(if_valid), 64'd0);
    applyStimulus(1'b1, 1'b0, 64'h0);
    checkFetch("C c7", 1'b1, 8'h44);
    checkOutput("C c7 if_valid", 64'(if_valid), 64'd0);
    applyStimulus(1'b1, 1'b0, 64'h0);
    checkHead("C c8", 1'b1, 32'h1010, 64'h40);

    // Redirect during a handshake, to an unaligned target near the top of memory.
    applyStimulus(1'b1, 1'b1, 64'hFE);
    checkFetch("D c9", 1'b0, 8'h00);
    checkHead("D c9", 1'b1, 32'h1011, 64'h44);
    applyStimulus(1'b1, 1'b0, 64'h0);
    checkFetch("D c10", 1'b1, 8'hFC);
    checkOutput("D c10 if_valid", 64'(if_valid), 64'd0);
    applyStimulus(1'b1, 1'b0, 64'h0);
    checkFetch("D c11", 1'b1, 8'h00);
    checkOutput("D c11 if_valid", 64'(if_valid), 64'd0);
    applyStimulus(1'b1, 1'b0, 64'h0);
    checkHead("D c12", 1'b1, 32'h103F, 64'hFC);
    applyStimulus(1'b1, 1'b0, 64'h0);
    checkHead("D c13", 1'b1, 32'h1000, 64'h100);
    applyStimulus(1'b1, 1'b0, 64'h0);
    checkHead("D c14", 1'b1, 32'h1001, 64'h104);

    // Asynchronous reset with a full queue, then a clean restart at the reset PC.
    resetDut("F");
    applyStimulus(1'b1, 1'b0, 64'h0);
    repeat (3) applyStimulus(1'b0, 1'b0, 64'h0);
    checkHead("F c4", 1'b1, 32'h1000, 64'h0);
    #2;
    rst_n = 1'b0;
    #1;
    checkFetch("F async", 1'b0, 8'h00);
    checkHead("F async", 1'b0, 32'h00000013, 64'h0);
    resetDut("F2");
    checkFetch("F2 c0", 1'b1, 8'h00);
    applyStimulus(1'b1, 1'b0, 64'h0);
    applyStimulus(1'b1, 1'b0, 64'h0);
    checkHead("F2 c2", 1'b1, 32'h1000, 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
